awgn_output_scaler: RTL
=======================

// Module: awgn_output_scaler
// PURPOSE
//  Final Box-Muller stage, directly downstream of the square-root unit. Multiplies sqrt magnitude f
//  by the cos/sin pair (g0,g1) to form two Gaussian samples x0=f*g0, x1=f*g1. It rounds and saturates
//  both, buffers pairs in a small FIFO and emits them as one valid/ready stream (x0 first, then x1).
// PARAMETERS
//  FW          17  width of f, unsigned Q3.14
//  GW          16  width of g0/g1, signed Q1.15
//  OW          16  width of output sample, signed Q4.11
//  FRAC_SHIFT  18  right shift applied to product (Q5.29 -> Q4.11)
//  FIFO_DEPTH  4   pair entries in output FIFO (power of 2, >=4)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     f/g0/g1 valid this cycle
//  in_ready   out  1     block accepts a pair this cycle
//  f          in   FW    sqrt magnitude from square-root unit
//  g0         in   GW    cos term
//  g1         in   GW    sin term
//  out_valid  out  1     out_data valid
//  out_ready  in   1     consumer accepts out_data
//  out_data   out  OW    Gaussian sample
//  out_sel    out  1     0 = x0 of pair, 1 = x1 of pair
//  smp_count  out  32    samples delivered (out_valid&out_ready), wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset: all pipeline valids 0, FIFO empty, phase 0; out_valid=0, out_data=0, out_sel=0,
//   smp_count=0, in_ready=1 once rst_n deasserted. Reset mid-operation discards in-flight and buffered pairs.
//  Accept: transfer when in_valid&in_ready at rising edge; inputs ignored otherwise (upstream holds).
//  Pipeline, 3 registered stages: S1 captures f,g0,g1; S2 p_i = $signed({1'b0,f})*$signed(g_i),
//   FW+GW+1 bits; S3 r_i = (p_i + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up, arithmetic),
//   then saturate to [-2^(OW-1), 2^(OW-1)-1]; S3 result written to FIFO as one {x0,x1} entry.
//  Latency: pair accepted at edge k, FIFO empty, consumer ready -> x0 on out_data after edge k+3,
//   x1 after edge k+4. Sustained throughput 1 sample/cycle, i.e. one pair per 2 cycles.
//  Credit flow control: in_ready = (fifo_count + inflight) < FIFO_DEPTH, inflight = S1..S3 valids.
//   Combinational from registers only; no path from out_ready to in_ready. FIFO never overflows.
//  Output: head entry presented while FIFO non-empty; phase bit selects x0 (0) / x1 (1) -> out_sel.
//   x1 delivered -> phase returns 0, head popped. out_data/out_sel stable while out_valid&!out_ready.
//  Simultaneous FIFO write and pop in the same cycle: both take effect, count unchanged.
//   Write to an empty FIFO is visible next cycle, no bypass.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  smp_count increments on every out_valid&out_ready, including wrap.
// STRUCTURE
//  Shared package awgn_pkg: Q-format widths (FW,GW,OW), FRAC_SHIFT, typedef sample_pair_t {x0,x1}.
//  One sub-module: awgn_pair_fifo (sync FIFO of sample_pair_t, count output, async active-low reset).
//  Multiply/round/saturate as a function in awgn_pkg, used twice in S2/S3.
// TESTING
//  Basic: f=16384 (1.0), g0=16384, g1=-16384 -> out_data 1024 (sel 0) then -1024 (sel 1), x0 at k+3.
//  Rounding: f=8, g0=16384, g1=-16384 -> x0=1 (p=2^17 rounds up), x1=0 (-2^17 rounds to 0).
//  Saturation, FRAC_SHIFT=14: f=131071, g0=32767, g1=-32768 -> x0=32767, x1=-32768.
//  Backpressure: out_ready=0, in_valid=1 for 8 cycles -> exactly 4 pairs accepted, in_ready=0 after;
//   release out_ready -> 8 samples in order, no loss/duplication, in_ready reasserts.
//  Streaming: in_valid and out_ready held 1, 100 random pairs -> bit-exact vs model, 1 sample/cycle.
//  Reset mid-op: assert rst_n=0 with 3 pairs buffered -> out_valid=0, smp_count=0 immediately.
//   Counter wrap: force/preload smp_count=32'hFFFF_FFFF, one transfer -> 0.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared Box-Muller output definitions: Q-format widths, sample pair type and
// the multiply / round-half-up / saturate helpers used by the output scaler.
package awgn_pkg;

  localparam int FW         = 17;  // f, unsigned Q3.14
  localparam int GW         = 16;  // g0/g1, signed Q1.15
  localparam int OW         = 16;  // output sample, signed Q4.11
  localparam int PW         = FW + GW + 1;
  localparam int FRAC_SHIFT = 18;

  typedef logic signed [PW-1:0] product_t;
  typedef logic signed [OW-1:0] sample_t;

  typedef struct packed {
    sample_t x0;
    sample_t x1;
  } sample_pair_t;

  typedef enum logic {PH_X0, PH_X1} phase_t;

  localparam logic signed [PW:0] SAT_MAX = (PW+1)'((1 <<< (OW-1)) - 1);
  localparam logic signed [PW:0] SAT_MIN = -SAT_MAX - 1;

  // f is unsigned, so it is zero-extended before the signed multiply.
  function automatic product_t mul_fg(input logic [FW-1:0] f,
                                      input logic signed [GW-1:0] g);
    product_t fe;
    product_t ge;
    fe = product_t'({1'b0, f});
    ge = product_t'(g);
    return fe * ge;
  endfunction

  // One guard bit above the product keeps the rounding add from wrapping.
  function automatic sample_t round_sat(input product_t p, input int shift);
    logic signed [PW:0] sum;
    logic signed [PW:0] r;
    sum = (PW+1)'(p) + ((PW+1)'(1) <<< (shift - 1));
    r   = sum >>> shift;
    if (r > SAT_MAX)      return sample_t'(SAT_MAX);
    else if (r < SAT_MIN) return sample_t'(SAT_MIN);
    else                  return sample_t'(r);
  endfunction

endpackage

// File: rtl/awgn_pair_fifo.sv
// Synchronous FIFO of {x0,x1} sample pairs with occupancy count.
// Write into an empty FIFO becomes visible the following cycle (no bypass).
module awgn_pair_fifo
  import awgn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  sample_pair_t             wr_data,
  input  logic                     rd_en,
  output sample_pair_t             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sample_pair_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign do_wr   = wr_en && ((count != CW'(DEPTH)) || do_rd);
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count do, so it can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: clocked state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/awgn_output_scaler.sv
// Final Box-Muller stage: x_i = round_sat(f * g_i), buffered as pairs and
// streamed out x0 then x1 under credit-based input flow control.
module awgn_output_scaler #(
  parameter int FRAC_SHIFT = awgn_pkg::FRAC_SHIFT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [awgn_pkg::FW-1:0]           f,
  input  logic signed [awgn_pkg::GW-1:0]    g0,
  input  logic signed [awgn_pkg::GW-1:0]    g1,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [awgn_pkg::OW-1:0]    out_data,
  output logic                              out_sel,
  output logic [31:0]                       smp_count
);

  import awgn_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 s1_valid, s2_valid, s3_valid;
  logic [FW-1:0]        s1_f;
  logic signed [GW-1:0] s1_g0, s1_g1;
  product_t             s2_p0, s2_p1;
  sample_pair_t         s3_pair;
  sample_pair_t         head;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        inflight;
  phase_t               phase;
  logic [31:0]          sample_cnt;
  logic                 accept, deliver, pop;

  // Credits cover every pair already in the pipeline, so the FIFO cannot overflow
  // and out_ready never reaches in_ready combinationally.
  assign inflight = CW'(s1_valid) + CW'(s2_valid) + CW'(s3_valid);
  assign in_ready = (fifo_count + inflight) < CW'(FIFO_DEPTH);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_f  <= f;
      s1_g0 <= g0;
      s1_g1 <= g1;
    end
    if (s1_valid) begin
      s2_p0 <= mul_fg(s1_f, s1_g0);
      s2_p1 <= mul_fg(s1_f, s1_g1);
    end
    if (s2_valid) begin
      s3_pair.x0 <= round_sat(s2_p0, FRAC_SHIFT);
      s3_pair.x1 <= round_sat(s2_p1, FRAC_SHIFT);
    end
  end

  awgn_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s3_valid),
    .wr_data (s3_pair),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_sel   = (phase == PH_X1);
  assign out_data  = !out_valid ? '0 : ((phase == PH_X1) ? head.x1 : head.x0);
  assign deliver   = out_valid && out_ready;
  assign pop       = deliver && (phase == PH_X1);
  assign smp_count = sample_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= PH_X0;
      sample_cnt <= '0;
    end else if (deliver) begin
      phase      <= (phase == PH_X0) ? PH_X1 : PH_X0;
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

endmodule
